alt_norm_seq: RTL and testbench

- Sequential post-normalizer that sits directly downstream of the half-ALT multiplier datapath.
- Takes the multiplier's 6-bit unbiased exponent and 10-bit truncated fraction product, and left-normalizes the product one bit per clock.
- Emits the packed 16-bit {exponent, fraction} result word through a valid/ready handshake.
- Replaces the unrolled combinational normalize loop, so the multiplier output can be registered and timing closed.

---
 rtl/alt_norm_seq_if.sv | 29 ++
 rtl/alt_norm_seq.sv | 114 +++++++++++
 tb/tb_alt_norm_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alt_norm_seq_if.sv
// Handshake bundle between the half-ALT multiplier and its
// sequential post-normalizer.
interface alt_norm_seq_if #(
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W-1:0]       in_prod;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W-1:0] out_sum;
  logic [3:0]              out_shift;
  logic                    out_uflow;
  logic                    busy;

  modport master (
    output in_valid, in_exp, in_prod, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_shift, out_uflow, busy
  );

  modport slave (
    input  in_valid, in_exp, in_prod, out_ready,
    output in_ready, out_valid, out_sum,
    output out_shift, out_uflow, busy
  );
endinterface

// File: rtl/alt_norm_seq.sv
// One-bit-per-clock left normalizer for the half-ALT multiplier.
// Define ALT_NORM_UFLOW_FLUSH_EN to flush exponent underflow to zero.
module alt_norm_seq #(
  parameter int EXP_W     = 6,
  parameter int FRAC_W    = 10,
  parameter int MAX_SHIFT = 9
) (
  input logic           clk,
  input logic           rst,
  alt_norm_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [EXP_W-1:0] E_MIN =
    {1'b1, {(EXP_W-1){1'b0}}};

  state_t                  state;
  logic [EXP_W-1:0]        e;
  logic [FRAC_W-1:0]       p;
  logic [3:0]              cnt;
  logic                    valid_q;
  logic [EXP_W+FRAC_W-1:0] sum_q;
  logic [3:0]              shift_q;
  logic                    uflow_q;
`ifdef ALT_NORM_UFLOW_FLUSH_EN
  logic                    uflow;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_shift = shift_q;
  assign bus.out_uflow = uflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      e       <= '0;
      p       <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      shift_q <= '0;
      uflow_q <= 1'b0;
`ifdef ALT_NORM_UFLOW_FLUSH_EN
      uflow   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            e   <= bus.in_exp;
            p   <= bus.in_prod;
            cnt <= '0;
`ifdef ALT_NORM_UFLOW_FLUSH_EN
            uflow <= 1'b0;
`endif
            // Zero product has nothing to normalize.
            if (bus.in_prod == '0) begin
              sum_q   <= '0;
              shift_q <= '0;
              uflow_q <= 1'b0;
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (!p[FRAC_W-1] && cnt < 4'(MAX_SHIFT)) begin
            p   <= p << 1;
            e   <= e - 1'b1;
            cnt <= cnt + 4'd1;
`ifdef ALT_NORM_UFLOW_FLUSH_EN
            if (e == E_MIN)
              uflow <= 1'b1;
`endif
          end else begin
            shift_q <= cnt;
            valid_q <= 1'b1;
            state   <= DONE;
`ifdef ALT_NORM_UFLOW_FLUSH_EN
            sum_q   <= uflow ? '0 : {e, p};
            uflow_q <= uflow;
`else
            sum_q   <= {e, p};
            uflow_q <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALT_NORM_UFLOW_FLUSH_EN
  logic unused_emin;
  assign unused_emin = ^E_MIN;
`endif

endmodule

// File: tb/tb_alt_norm_seq.sv
// Directed-vector bench for alt_norm_seq: latency, backpressure,
// underflow handling and asynchronous reset abort.
module tb_alt_norm_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  alt_norm_seq_if #(.EXP_W(6), .FRAC_W(10)) bus ();

  alt_norm_seq #(
    .EXP_W(6), .FRAC_W(10), .MAX_SHIFT(9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic send(input logic [5:0] ex,
                      input logic [9:0] pr);
    int n = 0;
    bus.in_exp   = ex;
    bus.in_prod  = pr;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL send_ready got=%b want=1",
               bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.out_valid, bus.busy, bus.out_uflow} !== 3'b000 ||
        bus.out_sum !== 16'h0 || bus.out_shift !== 4'h0)
      $display("FAIL reset_out v=%b b=%b s=%h sh=%0d want 0",
               bus.out_valid, bus.busy, bus.out_sum,
               bus.out_shift);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_rdy rdy=%b busy=%b want 1/0",
               bus.in_ready, bus.busy);
    else passed++;
  endtask

  task automatic run_vec(input string nm,
                         input logic [5:0] ex,
                         input logic [9:0] pr,
                         input logic [15:0] w_sum,
                         input logic [3:0] w_sh,
                         input logic w_uf,
                         input int w_lat);
    int lat;
    bus.out_ready = 1'b1;
    send(ex, pr);
    wait_valid(lat);
    total++;
    if (lat != w_lat)
      $display("FAIL %s_lat got=%0d want=%0d", nm, lat, w_lat);
    else passed++;
    total++;
    if (bus.out_sum !== w_sum || bus.out_shift !== w_sh ||
        bus.out_uflow !== w_uf)
      $display("FAIL %s_res sum=%h sh=%0d uf=%b want %h %0d %b",
               nm, bus.out_sum, bus.out_shift, bus.out_uflow,
               w_sum, w_sh, w_uf);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL %s_drop v=%b rdy=%b want 0/1",
               nm, bus.out_valid, bus.in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    run_vec("msb",  6'd3,  10'h200, 16'h0E00, 4'd0, 1'b0, 2);
    run_vec("lsb",  6'd5,  10'h001, 16'hF200, 4'd9, 1'b0, 11);
    run_vec("zero", 6'd17, 10'h000, 16'h0000, 4'd0, 1'b0, 1);
  endtask

  task automatic test_uflow();
`ifdef ALT_NORM_UFLOW_FLUSH_EN
    run_vec("uflow", 6'b100001, 10'h004,
            16'h0000, 4'd7, 1'b1, 9);
`else
    run_vec("wrap", 6'b100001, 10'h004,
            16'h6A00, 4'd7, 1'b0, 9);
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    bus.out_ready = 1'b0;
    send(6'd0, 10'h080);
    wait_valid(lat);
    total++;
    if (lat != 4 || bus.out_sum !== 16'hFA00)
      $display("FAIL bp_first lat=%0d sum=%h want 4 FA00",
               lat, bus.out_sum);
    else passed++;
    bus.in_exp   = 6'd1;
    bus.in_prod  = 10'h3FF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_sum !== 16'hFA00 || bus.out_shift !== 4'd2)
        bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL bp_hold bad_cycles=%0d want 0", bad);
    else passed++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL bp_hs v=%b busy=%b want 0/0",
               bus.out_valid, bus.busy);
    else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1)
      $display("FAIL bp_accept busy=%b want 1", bus.busy);
    else passed++;
    wait_valid(lat);
    total++;
    if (lat != 2 || bus.out_sum !== 16'h07FF ||
        bus.out_shift !== 4'd0)
      $display("FAIL bp_second lat=%0d sum=%h sh=%0d want 2 07FF 0",
               lat, bus.out_sum, bus.out_shift);
    else passed++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    bus.out_ready = 1'b1;
    send(6'd5, 10'h001);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_sum !== 16'h0 || bus.out_shift !== 4'h0)
      $display("FAIL abort_out v=%b b=%b s=%h sh=%0d want 0",
               bus.out_valid, bus.busy, bus.out_sum,
               bus.out_shift);
    else passed++;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL abort_rdy got=%b want 1", bus.in_ready);
    else passed++;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL abort_noval cycles=%0d want 0", seen);
    else passed++;
    run_vec("post", 6'd4, 10'h040, 16'h0600, 4'd3, 1'b0, 5);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_uflow();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
